// File: rtl/if_fetch.sv
// Instruction-fetch front end: PC, one-word fetch buffer feeding IF/ID.
// Define IF_FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets (AddrErr/BadVAddr).
module if_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        ExceptionFlush,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemRdy,
    input  logic [31:0] ImemRdata,
    output logic [31:0] Instruction,
    output logic [31:0] PCAdd4,
    output logic        InstrValid,
    output logic        AddrErr,
    output logic [31:0] BadVAddr
);

    localparam int unsigned W = 32;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1
`ifdef IF_FETCH_ALIGN_CHECK_EN
        ,ADDR_ERR = 2'd2
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic           buf_valid_q, buf_valid_d;
    logic [W-1:0]   buf_instr_q, buf_instr_d;
    logic [W-1:0]   buf_pc4_q, buf_pc4_d;
    logic           consume, space, fire;
    logic [W-1:0]   pc_plus4;
`ifdef IF_FETCH_ALIGN_CHECK_EN
    logic           addr_err_q, addr_err_d;
    logic [W-1:0]   bad_vaddr_q, bad_vaddr_d;
`endif

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            buf_valid_q <= 1'b0;
            buf_instr_q <= '0;
            buf_pc4_q   <= '0;
`ifdef IF_FETCH_ALIGN_CHECK_EN
            addr_err_q  <= 1'b0;
            bad_vaddr_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
`ifdef IF_FETCH_ALIGN_CHECK_EN
            addr_err_q  <= addr_err_d;
            bad_vaddr_q <= bad_vaddr_d;
`endif
        end
    end

    // Next state: flush > redirect > fire > consume
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
`ifdef IF_FETCH_ALIGN_CHECK_EN
        addr_err_d  = addr_err_q;
        bad_vaddr_d = bad_vaddr_q;
`endif
        pc_plus4 = pc_q + W'(4);
        consume  = buf_valid_q & ~Stall;
        space    = ~buf_valid_q | consume;
        ImemReq  = (state_q == RUN) & space & ~Redirect & ~ExceptionFlush;
        fire     = ImemReq & ImemRdy;

        if (state_q == BOOT) begin
            state_d = RUN;
        end

        if (ExceptionFlush) begin
            state_d     = RUN;
            pc_d        = EXC_VECTOR;
            buf_valid_d = 1'b0;
            buf_instr_d = '0;
`ifdef IF_FETCH_ALIGN_CHECK_EN
            addr_err_d  = 1'b0;
        end else if (state_q == ADDR_ERR) begin
            // Parked until CP0 flushes; redirects are ignored here.
            state_d = ADDR_ERR;
`endif
        end else if (Redirect) begin
            buf_valid_d = 1'b0;
            buf_instr_d = '0;
`ifdef IF_FETCH_ALIGN_CHECK_EN
            if (RedirectPC[1:0] != 2'b00) begin
                state_d     = ADDR_ERR;
                addr_err_d  = 1'b1;
                bad_vaddr_d = RedirectPC;
            end else begin
                pc_d = RedirectPC;
            end
`else
            pc_d = RedirectPC & 32'hFFFF_FFFC;
`endif
        end else if (fire) begin
            buf_valid_d = 1'b1;
            buf_instr_d = ImemRdata;
            buf_pc4_d   = pc_plus4;
            pc_d        = pc_plus4;
        end else if (consume) begin
            buf_valid_d = 1'b0;
            buf_instr_d = '0;
        end
    end

    assign ImemAddr    = pc_q;
    assign Instruction = buf_instr_q;
    assign PCAdd4      = buf_pc4_q;
    assign InstrValid  = buf_valid_q;
`ifdef IF_FETCH_ALIGN_CHECK_EN
    assign AddrErr     = addr_err_q;
    assign BadVAddr    = bad_vaddr_q;
`else
    assign AddrErr     = 1'b0;
    assign BadVAddr    = '0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: expected instruction stream modelled as a queue of
// (word, PC+4) entries; directed test-plan sequences followed by randomized traffic.
module tb_if_fetch;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;

    logic        CLK, RSTn, Stall, Redirect, ExceptionFlush, ImemRdy;
    logic [31:0] RedirectPC, ImemRdata, ImemAddr, Instruction, PCAdd4, BadVAddr;
    logic        ImemReq, InstrValid, AddrErr;

    if_fetch dut (
        .CLK(CLK), .RSTn(RSTn), .Stall(Stall), .Redirect(Redirect),
        .RedirectPC(RedirectPC), .ExceptionFlush(ExceptionFlush),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemRdy(ImemRdy),
        .ImemRdata(ImemRdata), .Instruction(Instruction), .PCAdd4(PCAdd4),
        .InstrValid(InstrValid), .AddrErr(AddrErr), .BadVAddr(BadVAddr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_1E69;
    endfunction

    // Memory returns a deterministic function of the requested address
    assign ImemRdata = mem_word(ImemAddr);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    entry_t      sb[$];
    logic [31:0] m_fetch;
    logic [31:0] m_bad;
    bit          m_run, m_err;
    int          checks = 0;
    int          errors = 0;
    int          consumed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + reference model, evaluated mid-cycle before the next rising edge
    always @(negedge CLK) begin
        logic exp_req;
        if (!RSTn) begin
            check("rst_valid", 32'(InstrValid), 32'd0);
            check("rst_instr", Instruction, 32'h0);
            check("rst_pcadd4", PCAdd4, 32'h0);
            check("rst_req", 32'(ImemReq), 32'd0);
            check("rst_addr", ImemAddr, RESET_VECTOR);
            check("rst_addrerr", 32'(AddrErr), 32'd0);
            check("rst_badvaddr", BadVAddr, 32'h0);
            sb.delete();
            m_fetch = RESET_VECTOR;
            m_bad   = 32'h0;
            m_run   = 1'b0;
            m_err   = 1'b0;
        end else begin
            exp_req = m_run && !m_err && (sb.size() == 0 || !Stall) && !Redirect && !ExceptionFlush;
            check("imem_req", 32'(ImemReq), 32'(exp_req));
            if (exp_req) check("imem_addr", ImemAddr, m_fetch);
            check("instr_valid", 32'(InstrValid), 32'(sb.size() != 0));
            if (InstrValid && sb.size() != 0) begin
                check("instruction", Instruction, sb[0].instr);
                check("pcadd4", PCAdd4, sb[0].pc4);
            end else if (!InstrValid) begin
                check("bubble_nop", Instruction, 32'h0);
            end
            check("addr_err", 32'(AddrErr), 32'(m_err));
            check("bad_vaddr", BadVAddr, m_bad);

            if (ExceptionFlush) begin
                sb.delete();
                m_fetch = EXC_VECTOR;
                m_err   = 1'b0;
            end else if (m_err) begin
                // stuck until flush
            end else if (Redirect) begin
                sb.delete();
`ifdef IF_FETCH_ALIGN_CHECK_EN
                if (RedirectPC % 4 != 0) begin
                    m_err = 1'b1;
                    m_bad = RedirectPC;
                end else begin
                    m_fetch = RedirectPC;
                end
`else
                m_fetch = RedirectPC - (RedirectPC % 4);
`endif
            end else begin
                if (sb.size() != 0 && !Stall) begin
                    void'(sb.pop_front());
                    consumed++;
                end
                if (exp_req && ImemRdy) begin
                    sb.push_back('{instr: mem_word(m_fetch), pc4: m_fetch + 32'd4});
                    m_fetch = m_fetch + 32'd4;
                end
            end
            m_run = 1'b1;
        end
    end

    task automatic drive(input logic stall, input logic rdy, input logic redir,
                         input logic [31:0] target, input logic flush, input int n);
        Stall          = stall;
        ImemRdy        = rdy;
        Redirect       = redir;
        RedirectPC     = target;
        ExceptionFlush = flush;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        logic [31:0] tgt;
        int          consumed_before;
        RSTn = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3);
        RSTn = 1'b1;

        // Peak throughput from reset
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 20);
        consumed_before = consumed;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 10);
        check("throughput", 32'(consumed - consumed_before), 32'd10);

        // Memory not ready, then stalled with a full buffer
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 3);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 2);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3);

        // Redirect with memory ready, then wrap at the top of memory
        drive(1'b0, 1'b1, 1'b1, 32'h8000_1000, 1'b0, 1);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4);
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3);
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4);

        // Misaligned redirect
        drive(1'b0, 1'b1, 1'b1, 32'h8000_1002, 1'b0, 1);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0:       tgt = 32'h8000_1000;
                1:       tgt = 32'hFFFF_FFFC;
                2:       tgt = 32'h8000_1002;
                3:       tgt = $urandom & 32'hFFFF_FFFC;
                default: tgt = $urandom;
            endcase
            drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0), tgt, ($urandom_range(0, 49) == 0), 1);
        end

        // Asynchronous reset mid-stream
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 5);
        RSTn = 1'b0;
        #1;
        check("async_rst_valid", 32'(InstrValid), 32'd0);
        check("async_rst_addr", ImemAddr, RESET_VECTOR);
        check("async_rst_req", 32'(ImemReq), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 2);
        RSTn = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
